rr_grant_scheduler: RTL and testbench

Round-robin scheduler that shares one resource among `NUM_REQ` requesters using a rotating one-hot priority token, the same rotation the Moore rotator produces. It sits in front of the shared resource and issues a registered one-hot grant with a bounded hold time, so no requester can starve the others. All outputs are Moore-style and come directly from registers.

---
 rtl/rr_sched_pkg.sv | 37 +++
 rtl/rr_pick.sv | 32 +++
 rtl/rr_grant_scheduler.sv | 112 +++++++++++
 tb/tb_rr_grant_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package rr_sched_pkg;

  localparam int MAX_REQ = 64;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits of vec up by one position, bit n-1 wrapping to bit 0.
  function automatic logic [MAX_REQ-1:0] rotate_onehot(input logic [MAX_REQ-1:0] vec,
                                                       input int n);
    logic [MAX_REQ-1:0] rot;
    rot = '0;
    for (int i = 0; i < MAX_REQ - 1; i++) begin
      if (i < n - 1) rot[i+1] = vec[i];
    end
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i == n - 1) rot[0] = vec[i];
    end
    return rot;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req at or above the token, wrapping.
// Pure logic, zero latency; pick is all-zero and pick_any low when nothing requests.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] token,
  output logic [NUM_REQ-1:0] pick,
  output logic               pick_any
);

  logic [2*NUM_REQ-1:0] hit;
  int                   base;

  // Search a doubled request window starting at the token position.
  always_comb begin
    base = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (token[i]) base = i;
    end
    hit      = '0;
    pick_any = 1'b0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!pick_any && req[i % NUM_REQ] && (i >= base) && (i < base + NUM_REQ)) begin
        hit[i]   = 1'b1;
        pick_any = 1'b1;
      end
    end
    pick = hit[NUM_REQ-1:0] | hit[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler with registered one-hot grant, bounded hold and
// one dead cycle between owners; grant appears the edge a request is sampled.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] token, token_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic               owner_req;
  logic               drop_grant;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req     (req),
    .token   (token),
    .pick    (pick),
    .pick_any(pick_any)
  );

  // Dropped request and hold expiry collapse into one release.
  assign owner_req  = |(req & gnt);
  assign drop_grant = (state == GRANT) && (!owner_req || (cnt == CNT_W'(MAX_HOLD)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      token     <= NUM_REQ'(1);
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      token     <= token_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= gnt_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    token_nxt = token;
    case (state)
      IDLE, RELEASE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (drop_grant) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          // Owner moves to lowest priority: token lands just above it.
          token_nxt = NUM_REQ'(rotate_onehot(MAX_REQ'(gnt), NUM_REQ));
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    case (state)
      IDLE, RELEASE: begin
        gnt_nxt    = pick;
        gnt_id_nxt = ID_W'(onehot_to_index(MAX_REQ'(pick)));
      end
      GRANT: begin
        if (drop_grant) begin
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
        end
      end
      default: begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed vector table, reset corner cases and
// randomized requests against an owner/token reference model.
module tb_rr_grant_scheduler;

  localparam int N = 4;
  localparam int H = 4;
  localparam int WAIT_MAX = (N - 1) * (H + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '1;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  int checks = 0;
  int errors = 0;

  rr_grant_scheduler #(
    .NUM_REQ (N),
    .MAX_HOLD(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how long, and where the search starts.
  int           owner = -1;
  int           held  = 0;
  int           tok   = 0;
  logic [N-1:0] req_s = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1;
      held  = 0;
      tok   = 0;
      req_s = '0;
    end else begin
      req_s = req;
      if (owner >= 0) begin
        if ((((req >> owner) & 4'd1) == 4'd0) || (held == H)) begin
          tok   = (owner + 1) % N;
          owner = -1;
          held  = 0;
        end else begin
          held++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (owner < 0 && (((req >> ((tok + k) % N)) & 4'd1) != 4'd0)) begin
            owner = (tok + k) % N;
            held  = 1;
          end
        end
      end
    end
  end

  function automatic logic [N-1:0] model_gnt();
    return (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
  endfunction

  // Per-cycle checks: model agreement, invariants, hold length, handover gap, wait bound.
  logic [N-1:0] prev_gnt = '0;
  int           run = 0;
  int           wcnt[N];
  bit           served[N];

  always @(negedge clk) begin
    chk("model_gnt", int'(gnt), int'(model_gnt()));
    chk("model_id", int'(gnt_id), (owner >= 0) ? owner : 0);
    chk("valid_or", int'(gnt_valid), int'(|gnt));
    chk("onehot0", int'($onehot0(gnt)), 1);
    if (!rst_n) begin
      prev_gnt = '0;
      run      = 0;
      for (int i = 0; i < N; i++) begin
        wcnt[i]   = 0;
        served[i] = 1'b0;
      end
    end else begin
      if (gnt != 0 && gnt == prev_gnt) run++;
      else run = (gnt != 0) ? 1 : 0;
      chk("hold_le_max", int'(run <= H), 1);
      chk("handover_gap", int'(prev_gnt != 0 && gnt != 0 && gnt != prev_gnt), 0);
      prev_gnt = gnt;
      for (int i = 0; i < N; i++) begin
        if (!req_s[i]) begin
          wcnt[i]   = 0;
          served[i] = 1'b0;
        end else if (gnt[i]) begin
          wcnt[i]   = 0;
          served[i] = 1'b1;
        end else if (!served[i]) begin
          wcnt[i]++;
          chk($sformatf("wait_bound[%0d]", i), int'(wcnt[i] <= WAIT_MAX), 1);
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   id;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [N-1:0] r, input logic [N-1:0] g,
                              input logic [1:0] id, input int n);
    vec_t v;
    v.req = r;
    v.gnt = g;
    v.id  = id;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    // Full contention, then early release, wrap-around and simultaneous drop/expiry.
    add(4'b1111, 4'b0001, 2'd0, 4);
    add(4'b1111, 4'b0000, 2'd0, 1);
    add(4'b1111, 4'b0010, 2'd1, 4);
    add(4'b1111, 4'b0000, 2'd0, 1);
    add(4'b1111, 4'b0100, 2'd2, 4);
    add(4'b1111, 4'b0000, 2'd0, 1);
    add(4'b1111, 4'b1000, 2'd3, 4);
    add(4'b1111, 4'b0000, 2'd0, 1);
    add(4'b1111, 4'b0001, 2'd0, 1);
    add(4'b0100, 4'b0000, 2'd0, 1);
    add(4'b0100, 4'b0100, 2'd2, 2);
    add(4'b0000, 4'b0000, 2'd0, 1);
    add(4'b0101, 4'b0001, 2'd0, 4);
    add(4'b0100, 4'b0000, 2'd0, 1);
    add(4'b0110, 4'b0010, 2'd1, 1);

    repeat (5) @(negedge clk);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_valid", int'(gnt_valid), 0);
    chk("reset_id", int'(gnt_id), 0);

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      req = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("tbl_gnt[%0d]", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl_valid[%0d]", i), int'(gnt_valid), int'(tbl[i].gnt != 0));
      chk($sformatf("tbl_id[%0d]", i), int'(gnt_id), int'(tbl[i].id));
      @(negedge clk);
    end

    // Asynchronous reset while requester 1 owns the resource.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_valid", int'(gnt_valid), 0);
    chk("async_rst_id", int'(gnt_id), 0);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", int'(gnt), 4'b0001);
    chk("post_rst_id", int'(gnt_id), 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = 4'($urandom);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
